// File: rtl/noc_pkg.sv
// Flit layout shared by the binary-tree NoC endpoints: {dest, payload}.
package noc_pkg;

    localparam int DATA_W    = 34;
    localparam int ADDR_W    = 2;
    localparam int ADDR_MSB  = DATA_W - 1;
    localparam int ADDR_LSB  = DATA_W - ADDR_W;
    localparam int PAYLOAD_W = DATA_W - ADDR_W;

    typedef logic [DATA_W-1:0]    flit_t;
    typedef logic [ADDR_W-1:0]    addr_t;
    typedef logic [PAYLOAD_W-1:0] payload_t;

    function automatic addr_t flit_addr(input flit_t flit);
        return flit[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic flit_t flit_pack(input addr_t dest, input payload_t payload);
        return {dest, payload};
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered full flag.
module noc_sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW:0]    count;
    logic [PtrW:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + (PtrW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - (PtrW+1)'(1);
        end
    end

    // full is held high in reset so writers stall until the first clean cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            count <= count_nxt;
            full  <= (count_nxt == (PtrW+1)'(Depth));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/leaf_net_iface.sv
// Leaf endpoint of the binary-tree NoC: TX FIFO toward the switch,
// 2-entry RX skid toward the PE, address checks, counters, error pulses.
module leaf_net_iface
    import noc_pkg::*;
#(
    parameter int DataWidth = DATA_W,
    parameter int AddrWidth = ADDR_W,
    parameter int MyAddr    = 0,
    parameter int FifoDepth = 4,
    parameter int CntWidth  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [DataWidth-AddrWidth-1:0] i_pe_data,
    input  logic [AddrWidth-1:0]          i_pe_dest,
    input  logic                          i_pe_data_valid,
    output logic                          o_pe_data_ready,
    output logic [DataWidth-AddrWidth-1:0] o_pe_data,
    output logic                          o_pe_data_valid,
    input  logic                          i_pe_data_ready,
    output logic [DataWidth-1:0]          o_data,
    output logic                          o_data_valid,
    input  logic                          i_data_ready,
    input  logic [DataWidth-1:0]          i_data,
    input  logic                          i_data_valid,
    output logic                          o_data_ready,
    output logic [CntWidth-1:0]           o_tx_count,
    output logic [CntWidth-1:0]           o_rx_count,
    output logic                          o_err_self,
    output logic                          o_err_misroute
);

    localparam int PayW = DataWidth - AddrWidth;
    localparam logic [AddrWidth-1:0] MY = AddrWidth'(MyAddr);

    logic                 tx_full;
    logic                 tx_empty;
    logic                 rx_full;
    logic                 rx_empty;
    logic                 tx_self;
    logic                 rx_mine;
    logic [AddrWidth-1:0] rx_addr;

    assign tx_self = (i_pe_dest == MY);
    assign rx_addr = i_data[DataWidth-1 -: AddrWidth];
    assign rx_mine = (rx_addr == MY);

    assign o_pe_data_ready = !tx_full;
    assign o_data_valid    = !tx_empty;
    assign o_data_ready    = !rx_full;
    assign o_pe_data_valid = !rx_empty;

    noc_sync_fifo #(
        .Width (DataWidth),
        .Depth (FifoDepth)
    ) u_tx_fifo (
        .clk       (i_clk),
        .rst_n     (i_reset),
        .push      (i_pe_data_valid && !tx_self),
        .push_data ({i_pe_dest, i_pe_data}),
        .pop       (i_data_ready),
        .pop_data  (o_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // only payload bits are kept; the address is known to be ours
    noc_sync_fifo #(
        .Width (PayW),
        .Depth (2)
    ) u_rx_skid (
        .clk       (i_clk),
        .rst_n     (i_reset),
        .push      (i_data_valid && rx_mine),
        .push_data (i_data[PayW-1:0]),
        .pop       (i_pe_data_ready),
        .pop_data  (o_pe_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_tx_count     <= '0;
            o_rx_count     <= '0;
            o_err_self     <= 1'b0;
            o_err_misroute <= 1'b0;
        end else begin
            o_err_self     <= i_pe_data_valid && !tx_full && tx_self;
            o_err_misroute <= i_data_valid && !rx_full && !rx_mine;
            if (o_data_valid && i_data_ready) begin
                o_tx_count <= o_tx_count + CntWidth'(1);
            end
            if (o_pe_data_valid && i_pe_data_ready) begin
                o_rx_count <= o_rx_count + CntWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_leaf_net_iface.sv
// Randomised directed bench for leaf_net_iface against a queue-based model;
// a second instance with 4-bit counters exercises counter wrap.
module tb_leaf_net_iface;
    import noc_pkg::*;

    localparam logic [1:0] MY = 2'd0;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pe_data;
    logic [1:0]  i_pe_dest;
    logic        i_pe_data_valid;
    logic        i_pe_data_ready;
    logic        i_data_ready;
    logic [33:0] i_data;
    logic        i_data_valid;

    logic        o_pe_data_ready, o_pe_data_valid, o_data_valid, o_data_ready;
    logic [31:0] o_pe_data;
    logic [33:0] o_data;
    logic [15:0] o_tx_count, o_rx_count;
    logic        o_err_self, o_err_misroute;

    logic        b_pe_data_ready, b_pe_data_valid, b_data_valid, b_data_ready;
    logic [31:0] b_pe_data;
    logic [33:0] b_data;
    logic [3:0]  b_tx_count, b_rx_count;
    logic        b_err_self, b_err_misroute;

    always #5 i_clk = ~i_clk;

    leaf_net_iface #(.MyAddr(0), .FifoDepth(4), .CntWidth(16)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_pe_data(i_pe_data), .i_pe_dest(i_pe_dest),
        .i_pe_data_valid(i_pe_data_valid), .o_pe_data_ready(o_pe_data_ready),
        .o_pe_data(o_pe_data), .o_pe_data_valid(o_pe_data_valid),
        .i_pe_data_ready(i_pe_data_ready),
        .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
        .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
        .o_tx_count(o_tx_count), .o_rx_count(o_rx_count),
        .o_err_self(o_err_self), .o_err_misroute(o_err_misroute)
    );

    leaf_net_iface #(.MyAddr(0), .FifoDepth(4), .CntWidth(4)) u_dut4 (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_pe_data(i_pe_data), .i_pe_dest(i_pe_dest),
        .i_pe_data_valid(i_pe_data_valid), .o_pe_data_ready(b_pe_data_ready),
        .o_pe_data(b_pe_data), .o_pe_data_valid(b_pe_data_valid),
        .i_pe_data_ready(i_pe_data_ready),
        .o_data(b_data), .o_data_valid(b_data_valid), .i_data_ready(i_data_ready),
        .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(b_data_ready),
        .o_tx_count(b_tx_count), .o_rx_count(b_rx_count),
        .o_err_self(b_err_self), .o_err_misroute(b_err_misroute)
    );

    int n_vec = 0;
    int n_err = 0;

    // behavioural model: plain queues and modular counters
    flit_t       tx_q[$];
    logic [31:0] rx_q[$];
    logic [15:0] m_txc, m_rxc;
    logic [3:0]  m_txc4, m_rxc4;
    bit          m_eself, m_emis;
    bit          m_inrst = 1'b1;

    function automatic bit m_pe_rdy();
        return !m_inrst && (tx_q.size() < 4);
    endfunction

    function automatic bit m_d_rdy();
        return !m_inrst && (rx_q.size() < 2);
    endfunction

    task automatic model_edge();
        bit perdy;
        bit drdy;
        perdy = m_pe_rdy();
        drdy  = m_d_rdy();
        if (!i_reset) begin
            tx_q.delete();
            rx_q.delete();
            m_txc = '0; m_rxc = '0; m_txc4 = '0; m_rxc4 = '0;
            m_eself = 1'b0; m_emis = 1'b0;
            m_inrst = 1'b1;
        end else begin
            m_eself = 1'b0;
            m_emis  = 1'b0;
            if (tx_q.size() > 0 && i_data_ready) begin
                void'(tx_q.pop_front());
                m_txc  = m_txc + 1'b1;
                m_txc4 = m_txc4 + 1'b1;
            end
            if (i_pe_data_valid && perdy) begin
                if (i_pe_dest == MY) m_eself = 1'b1;
                else tx_q.push_back(flit_pack(i_pe_dest, i_pe_data));
            end
            if (rx_q.size() > 0 && i_pe_data_ready) begin
                void'(rx_q.pop_front());
                m_rxc  = m_rxc + 1'b1;
                m_rxc4 = m_rxc4 + 1'b1;
            end
            if (i_data_valid && drdy) begin
                if (flit_addr(i_data) == MY) rx_q.push_back(i_data[31:0]);
                else m_emis = 1'b1;
            end
            m_inrst = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [33:0] e_data;
        logic [31:0] e_pay;
        e_data = '0;
        e_pay  = '0;
        if (tx_q.size() > 0) e_data = tx_q[0];
        if (rx_q.size() > 0) e_pay = rx_q[0];
        check("pe_ready", o_pe_data_ready, m_pe_rdy());
        check("data_ready", o_data_ready, m_d_rdy());
        check("data_valid", o_data_valid, tx_q.size() > 0);
        check("data", o_data, e_data);
        check("pe_valid", o_pe_data_valid, rx_q.size() > 0);
        check("pe_data", o_pe_data, e_pay);
        check("tx_count", o_tx_count, m_txc);
        check("rx_count", o_rx_count, m_rxc);
        check("err_self", o_err_self, m_eself);
        check("err_misroute", o_err_misroute, m_emis);
        check("tx_count4", b_tx_count, m_txc4);
        check("rx_count4", b_rx_count, m_rxc4);
    endtask

    task automatic step();
        @(posedge i_clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        i_pe_data_valid = 1'b0;
        i_data_valid    = 1'b0;
    endtask

    initial begin
        int          k;
        int          sent;
        int          guard;
        bit          acc;
        logic [33:0] head_exp;

        i_reset = 1'b0;
        i_pe_data = 32'h0;
        i_pe_dest = 2'd2;
        i_data = '0;
        i_pe_data_valid = 1'b1;
        i_data_valid = 1'b1;
        i_pe_data_ready = 1'b1;
        i_data_ready = 1'b1;

        // reset with valids held high
        repeat (3) begin
            i_pe_data = $urandom;
            i_data = flit_pack(2'd0, $urandom);
            step();
        end
        check("rst_pe_ready", o_pe_data_ready, 0);
        check("rst_data_ready", o_data_ready, 0);
        idle();
        i_reset = 1'b1;
        step();
        check("rel_pe_ready", o_pe_data_ready, 1);
        check("rel_data_ready", o_data_ready, 1);

        // TX fill against a stalled switch
        i_data_ready = 1'b0;
        i_pe_dest = 2'd2;
        k = 1;
        for (int c = 0; c < 8; c++) begin
            i_pe_data_valid = (k <= 5);
            i_pe_data = 32'(k);
            acc = i_pe_data_valid && m_pe_rdy();
            step();
            if (acc) k++;
        end
        check("fill_ready_low", o_pe_data_ready, 0);
        head_exp = 34'h2_0000_0001;
        check("fill_head", o_data, head_exp);
        i_data_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            i_pe_data_valid = (k <= 5);
            i_pe_data = 32'(k);
            acc = i_pe_data_valid && m_pe_rdy();
            step();
            if (acc) k++;
        end
        check("tx_five", o_tx_count, 5);

        // self-addressed and misrouted traffic
        idle();
        i_pe_data_valid = 1'b1;
        i_pe_dest = MY;
        i_pe_data = $urandom;
        step();
        idle();
        check("self_pulse", o_err_self, 1);
        step();
        check("self_end", o_err_self, 0);
        check("self_nothing_out", o_data_valid, 0);
        i_data_valid = 1'b1;
        i_data = flit_pack(2'd3, $urandom);
        step();
        idle();
        check("mis_pulse", o_err_misroute, 1);
        check("mis_no_pe", o_pe_data_valid, 0);
        step();
        check("mis_end", o_err_misroute, 0);

        // RX full throughput
        i_pe_data_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check("tp_ready", o_data_ready, 1);
            i_data_valid = 1'b1;
            i_data = flit_pack(MY, $urandom);
            step();
        end
        idle();
        repeat (2) step();
        check("rx_eight", o_rx_count, 8);

        // RX backpressure, then random traffic on both paths
        i_pe_data_ready = 1'b0;
        repeat (3) begin
            i_data_valid = 1'b1;
            i_data = flit_pack(MY, $urandom);
            step();
        end
        check("bp_ready_low", o_data_ready, 0);
        sent = 0;
        guard = 0;
        while (sent < 100 && guard < 2000) begin
            i_data_valid = ($urandom_range(0, 3) != 0);
            i_data = flit_pack(($urandom_range(0, 7) == 0) ? 2'd3 : MY, $urandom);
            i_pe_data_ready = $urandom_range(0, 1);
            i_pe_data_valid = $urandom_range(0, 1);
            i_pe_dest = 2'($urandom_range(0, 3));
            i_pe_data = $urandom;
            i_data_ready = $urandom_range(0, 1);
            acc = i_data_valid && m_d_rdy();
            step();
            if (acc) sent++;
            guard++;
        end
        check("rx_sent", sent, 100);
        idle();
        i_pe_data_ready = 1'b1;
        i_data_ready = 1'b1;
        repeat (8) step();

        // counter wrap on the 4-bit instance
        i_reset = 1'b0;
        step();
        i_reset = 1'b1;
        step();
        sent = 0;
        guard = 0;
        while (sent < 17 && guard < 200) begin
            i_pe_data_valid = 1'b1;
            i_pe_dest = 2'($urandom_range(1, 3));
            i_pe_data = $urandom;
            acc = m_pe_rdy();
            step();
            if (acc) sent++;
            guard++;
        end
        idle();
        repeat (4) step();
        check("wrap4", b_tx_count, 1);
        check("tx17", o_tx_count, 17);

        // reset with TX FIFO half full
        i_data_ready = 1'b0;
        repeat (2) begin
            i_pe_data_valid = 1'b1;
            i_pe_dest = 2'd1;
            i_pe_data = $urandom;
            step();
        end
        idle();
        check("half_valid", o_data_valid, 1);
        i_reset = 1'b0;
        step();
        check("mid_rst_empty", o_data_valid, 0);
        check("mid_rst_tx", o_tx_count, 0);
        check("mid_rst_tx4", b_tx_count, 0);
        i_reset = 1'b1;
        i_data_ready = 1'b1;
        repeat (3) step();
        check("post_rst_empty", o_data_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
